uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 10 +
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - RIB slave bus bundle for the UART transmitter
interface uart_tx_fifo_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [31:0] data_o;

  modport master (output addr_i, output data_i, output we_i, input data_o);
  modport slave  (input addr_i, input data_i, input we_i, output data_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Registers answer reads combinationally; the serializer drains the FIFO onto tx_pin.
module uart_tx_fifo #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus,
  output logic           tx_pin,
  output logic           irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          tx_en;
  logic          overflow;
  logic [15:0]   baud;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    count4;

  state_t        state, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          pop, phase_end;

  logic [7:0]    addr_lo;
  logic          wr_ctrl, wr_status, wr_baud, wr_txdata;
  logic          full, empty, push, drop;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign addr_lo     = bus.addr_i[7:0];
  assign unused_bits = ^{bus.addr_i[31:8], bus.data_i[31:16]};

  assign wr_ctrl   = bus.we_i && (addr_lo == 8'h00);
  assign wr_status = bus.we_i && (addr_lo == 8'h04);
  assign wr_baud   = bus.we_i && (addr_lo == 8'h08);
  assign wr_txdata = bus.we_i && (addr_lo == 8'h0C);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_txdata && !full;
  assign drop  = wr_txdata && full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_en    <= 1'b0;
      overflow <= 1'b0;
      baud     <= BAUD_DIV_RST;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (wr_ctrl) tx_en <= bus.data_i[0];
      if (wr_baud) baud  <= bus.data_i[15:0];
      if (drop)
        overflow <= 1'b1;
      else if (wr_status && bus.data_i[3])
        overflow <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shift_q <= '0;
      div_q   <= 16'd1;
      phase_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign phase_end = (phase_q == div_q - 16'd1);

  // tx_d is the line level for the state being entered, keeping tx_pin a pure flop.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = mem[rd_ptr];
          div_d   = (baud == 16'd0) ? 16'd1 : baud;
          phase_d = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      DATA: begin
        if (phase_end) begin
          phase_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (phase_end) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign count4 = 4'(count);

  always_comb begin
    rdata = 32'h0;
    case (addr_lo)
      8'h00: rdata[0] = tx_en;
      8'h04: begin
        rdata[0]    = (state != IDLE);
        rdata[1]    = full;
        rdata[2]    = empty;
        rdata[3]    = overflow;
        rdata[11:8] = count4;
      end
      8'h08: rdata[15:0] = baud;
      default: rdata = 32'h0;
    endcase
  end

  assign bus.data_o = rdata;
  assign tx_pin     = tx_q;
  assign irq_o      = tx_en && empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_BAUD   = 32'h08;
  localparam logic [31:0] A_TXDATA = 32'h0C;

  logic clk;
  logic rst;
  logic tx_pin;
  logic irq_o;
  int   tests;
  int   fails;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.FIFO_DEPTH(8), .BAUD_DIV_RST(16'd434)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .tx_pin (tx_pin),
    .irq_o  (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
    @(negedge clk);
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.addr_i = a;
    #1;
    check(tag, bus.data_o, exp);
    bus.addr_i = 32'h0;
  endtask

  // Waits for the start bit, then samples every cycle of a 10*div frame.
  task automatic frame_check(input string tag, input int div, input logic [7:0] byte_v,
                             input int exp_idle);
    int         waited = 0;
    bit         seen   = 1'b0;
    int         bad    = 0;
    logic [9:0] bits   = '0;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, byte_v, 1'b0};
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (tx_pin == 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, " start"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " idle"}, 32'(waited - 1), 32'(exp_idle));
    for (int c = 0; c < 10 * div; c++) begin
      if (c > 0) @(negedge clk);
      if (c % div == 0) bits[c / div] = tx_pin;
      else if (tx_pin !== bits[c / div]) bad++;
    end
    check({tag, " bits"}, 32'(bits), 32'(exp_bits));
    check({tag, " glitch"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int lows;
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
    bus.we_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    check("rst tx_pin", 32'(tx_pin), 32'd1);
    check("rst irq", 32'(irq_o), 32'd0);
    read_check("rst status", A_STATUS, 32'h0000_0004);
    read_check("rst baud", A_BAUD, 32'h0000_01B2);
    read_check("rst ctrl", A_CTRL, 32'h0);
    read_check("baud alias hi addr", 32'h0100_0008, 32'h0000_01B2);
    bus_write(32'h10, 32'hFFFF_FFFF);
    read_check("unmapped read", 32'h10, 32'h0);
    read_check("txdata read", A_TXDATA, 32'h0);

    // Single frame, only the low byte of the write is sent
    bus_write(A_BAUD, 32'd4);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h1A5);
    frame_check("single", 4, 8'hA5, 0);
    read_check("single status", A_STATUS, 32'h0000_0004);
    check("single irq", 32'(irq_o), 32'd1);

    // Overflow: ninth byte dropped, then eight back-to-back frames
    bus_write(A_CTRL, 32'd0);
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'h10 + 32'(i));
    read_check("ovf status", A_STATUS, 32'h0000_080A);
    check("ovf irq", 32'(irq_o), 32'd0);
    bus_write(A_STATUS, 32'h8);
    read_check("ovf clear", A_STATUS, 32'h0000_0802);
    bus_write(A_CTRL, 32'd1);
    for (int i = 0; i < 8; i++)
      frame_check($sformatf("drain%0d", i), 4, 8'h10 + 8'(i), (i == 0) ? 0 : 1);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx_pin) lows++;
    end
    check("no ninth frame", 32'(lows), 32'd0);
    read_check("drain status", A_STATUS, 32'h0000_0004);
    check("drain irq", 32'(irq_o), 32'd1);

    // Baud change during bit 3 applies to the next frame only
    bus_write(A_TXDATA, 32'h00);
    fork
      frame_check("baud f1", 4, 8'h00, 0);
      begin
        repeat (16) @(negedge clk);
        bus_write(A_BAUD, 32'd2);
        bus_write(A_TXDATA, 32'hFF);
      end
    join
    frame_check("baud f2", 2, 8'hFF, 1);
    read_check("baud readback", A_BAUD, 32'h2);

    // Clearing tx_en mid-frame finishes the frame and holds the rest
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'h33);
    fork
      frame_check("txen f1", 4, 8'h33, 0);
      begin
        bus_write(A_TXDATA, 32'h44);
        bus_write(A_CTRL, 32'd0);
      end
    join
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx_pin) lows++;
    end
    check("txen hold", 32'(lows), 32'd0);
    read_check("txen status", A_STATUS, 32'h0000_0100);
    check("txen irq", 32'(irq_o), 32'd0);

    // Reset during DATA bit 0 of 0x44 (a low bit)
    bus_write(A_CTRL, 32'd1);
    repeat (6) @(negedge clk);
    check("pre-rst data bit", 32'(tx_pin), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid rst tx_pin", 32'(tx_pin), 32'd1);
    rst = 1'b1;
    read_check("mid rst status", A_STATUS, 32'h0000_0004);
    read_check("mid rst ctrl", A_CTRL, 32'h0);
    read_check("mid rst baud", A_BAUD, 32'h0000_01B2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
